bcd_display_scanner: RTL and testbench

// - Consumes BCD outputs of the cascaded c74160-style decade counters (4 digits, e.g. MM:SS) and

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/bcd_to_seg7.sv | 28 ++
 rtl/bcd_display_scanner.sv | 140 ++++++++++++++
 tb/tb_bcd_display_scanner.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment display path.
// Segment patterns are active-high in {g,f,e,d,c,b,a} order.
package seg7_pkg;

    localparam int DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        ST_GUARD,
        ST_SHOW
    } scan_state_e;

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-high 7-segment pattern.
// Codes above 9 render as a dash so bad counter values are visible.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] pat
);

    // Pure lookup; anything not a decimal digit falls through to the dash.
    always_comb begin
        pat = SEG_DASH;
        case (code)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// 4-digit multiplexed 7-segment scanner with per-frame snapshot,
// anti-ghost guard interval, leading-zero blanking and dash for bad codes.
module bcd_display_scanner
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD_CYC   = 64,
    parameter int SEG_ACT_LOW = 1,
    parameter int AN_ACT_LOW  = 1
)
(
    input  logic                  clk,
    input  logic                  mr,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   bcd,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_start
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD_CYC);

    // XOR masks turning active-high values into pin levels.
    localparam logic [6:0] SEG_POL = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic       DP_POL  = (SEG_ACT_LOW != 0);
    localparam logic [3:0] AN_POL  = (AN_ACT_LOW != 0) ? 4'hF : 4'h0;

    logic [CW-1:0]         cnt;
    logic [1:0]            idx;
    logic                  cap_pend;
    logic [4*DIGITS-1:0]   snap_bcd;
    logic [DIGITS-1:0]     snap_dp;
    logic                  snap_blz;

    logic                  wrap;
    logic                  capture;
    logic [CW-1:0]         cnt_nx;
    logic [1:0]            idx_nx;
    scan_state_e           st_nx;
    logic [4*DIGITS-1:0]   src_bcd;
    logic [DIGITS-1:0]     src_dp;
    logic                  src_blz;
    logic [3:0]            dig;
    logic [6:0]            pat;
    logic [DIGITS-1:0]     zero;
    logic [DIGITS-1:0]     blank;
    logic [6:0]            seg_ah;
    logic                  dp_ah;
    logic [DIGITS-1:0]     an_ah;

    assign wrap    = (cnt == CNT_LAST);
    assign cnt_nx  = wrap ? '0 : cnt + 1'b1;
    assign idx_nx  = wrap ? idx + 2'd1 : idx;
    assign capture = cap_pend | (wrap & (idx == 2'd3));
    assign st_nx   = (cnt_nx >= CNT_GUARD) ? ST_SHOW : ST_GUARD;

    // On a capture edge the display must already use the fresh values.
    assign src_bcd = capture ? bcd      : snap_bcd;
    assign src_dp  = capture ? dp_in    : snap_dp;
    assign src_blz = capture ? blank_lz : snap_blz;

    assign dig = src_bcd[{idx_nx, 2'b00} +: 4];

    bcd_to_seg7 u_dec (
        .code (dig),
        .pat  (pat)
    );

    // A digit is a leading zero only if it and everything above is 0 with no dp.
    always_comb begin
        for (int k = 0; k < DIGITS; k++) begin
            zero[k] = (src_bcd[4*k +: 4] == 4'd0) & ~src_dp[k];
        end
        blank[3] = src_blz & zero[3];
        blank[2] = blank[3] & zero[2];
        blank[1] = blank[2] & zero[1];
        blank[0] = 1'b0;
    end

    assign seg_ah = blank[idx_nx] ? SEG_BLANK : pat;
    assign dp_ah  = ~blank[idx_nx] & src_dp[idx_nx];
    assign an_ah  = 4'b0001 << idx_nx;

    // Scan counter, capture request and registered display outputs.
    always_ff @(posedge clk or posedge mr) begin
        if (mr) begin
            cnt         <= '0;
            idx         <= '0;
            cap_pend    <= 1'b1;
            frame_start <= 1'b0;
            seg         <= SEG_POL;
            dp          <= DP_POL;
            an          <= AN_POL;
        end else if (!en) begin
            cnt         <= '0;
            idx         <= '0;
            cap_pend    <= 1'b1;
            frame_start <= 1'b0;
            seg         <= SEG_POL;
            dp          <= DP_POL;
            an          <= AN_POL;
        end else begin
            cnt         <= cnt_nx;
            idx         <= idx_nx;
            cap_pend    <= 1'b0;
            frame_start <= capture;
            unique case (st_nx)
                ST_SHOW: begin
                    seg <= seg_ah ^ SEG_POL;
                    dp  <= dp_ah ^ DP_POL;
                    an  <= an_ah ^ AN_POL;
                end
                default: begin
                    seg <= SEG_POL;
                    dp  <= DP_POL;
                    an  <= AN_POL;
                end
            endcase
        end
    end

    // Frame snapshot so a whole scan shows one consistent set of digits.
    always_ff @(posedge clk or posedge mr) begin
        if (mr) begin
            snap_bcd <= '0;
            snap_dp  <= '0;
            snap_blz <= 1'b0;
        end else if (en && capture) begin
            snap_bcd <= bcd;
            snap_dp  <= dp_in;
            snap_blz <= blank_lz;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner (REFRESH_DIV=8, GUARD_CYC=2).
// Behavioural frame model plus hand-computed literal expectations.
module tb_bcd_display_scanner;

    localparam int DIV   = 8;
    localparam int GRD   = 2;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        mr;
    logic        en;
    logic [15:0] bcd;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;

    int n_chk  = 0;
    int n_pass = 0;

    bcd_display_scanner #(
        .REFRESH_DIV (DIV),
        .GUARD_CYC   (GRD),
        .SEG_ACT_LOW (1),
        .AN_ACT_LOW  (1)
    ) dut (
        .clk         (clk),
        .mr          (mr),
        .en          (en),
        .bcd         (bcd),
        .dp_in       (dp_in),
        .blank_lz    (blank_lz),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    // Model: position in frame (edges since restart), frame digit values.
    int   p = 0;
    bit   pend = 1'b1;
    int   fd[4];
    bit   fdp[4];
    bit   fblz;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_fs;

    function automatic logic [6:0] pat_of(input int d);
        logic [6:0] t[10];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (d > 9) return 7'h40;
        return t[d];
    endfunction

    task automatic model_outputs();
        int  c;
        int  i;
        bit  bl;
        c = p % DIV;
        i = p / DIV;
        if (c < GRD) begin
            e_an  = 4'hF;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
        end else begin
            bl = fblz && (i > 0);
            for (int j = i; j < 4; j++)
                if (fd[j] != 0 || fdp[j]) bl = 1'b0;
            e_an  = ~(4'b0001 << i);
            e_seg = bl ? 7'h7F : ~pat_of(fd[i]);
            e_dp  = bl ? 1'b1 : ~fdp[i];
        end
    endtask

    // Model update on each edge, then every output compared just after.
    initial begin
        for (int k = 0; k < 4; k++) begin
            fd[k]  = 0;
            fdp[k] = 1'b0;
        end
        fblz = 1'b0;
        forever begin
            @(posedge clk);
            if (mr) begin
                p    = 0;
                pend = 1'b1;
                e_fs = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    fd[k]  = 0;
                    fdp[k] = 1'b0;
                end
                fblz = 1'b0;
            end else if (!en) begin
                p    = 0;
                pend = 1'b1;
                e_fs = 1'b0;
            end else begin
                p    = (p + 1) % FRAME;
                e_fs = pend || (p == 0);
                pend = 1'b0;
                if (e_fs) begin
                    for (int k = 0; k < 4; k++) begin
                        fd[k]  = int'(bcd[4*k +: 4]);
                        fdp[k] = dp_in[k];
                    end
                    fblz = blank_lz;
                end
            end
            model_outputs();
            #1;
            chk("m_an",  int'(an),  int'(e_an));
            chk("m_seg", int'(seg), int'(e_seg));
            chk("m_dp",  int'(dp),  int'(e_dp));
            chk("m_fs",  int'(frame_start), int'(e_fs));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic goto(input int tgt);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (p != tgt && n < 4 * FRAME);
        chk("goto", p, tgt);
    endtask

    task automatic lit(input string name, input logic [3:0] xa,
                       input logic [6:0] xs, input logic xd);
        chk({name, "_an"},  int'(an),  int'(xa));
        chk({name, "_seg"}, int'(seg), int'(xs));
        chk({name, "_dp"},  int'(dp),  int'(xd));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mr       = 1'b1;
        en       = 1'b0;
        bcd      = 16'h0000;
        dp_in    = 4'b0000;
        blank_lz = 1'b0;
        cyc(3);
        lit("rst", 4'hF, 7'h7F, 1'b1);
        chk("rst_fs", int'(frame_start), 0);

        // Scan 1234: d0=4 d1=3 d2=2 d3=1
        mr  = 1'b0;
        en  = 1'b1;
        bcd = 16'h1234;
        cyc(1);
        chk("start_fs", int'(frame_start), 1);
        chk("start_an", int'(an), 4'hF);
        cyc(1);
        lit("d0_4", 4'b1110, 7'h19, 1'b1);
        cyc(8);
        lit("d1_3", 4'b1101, 7'h30, 1'b1);
        cyc(8);
        lit("d2_2", 4'b1011, 7'h24, 1'b1);
        cyc(8);
        lit("d3_1", 4'b0111, 7'h79, 1'b1);
        cyc(6);
        chk("frame_fs", int'(frame_start), 1);

        // No tearing: change mid-frame at idx 2
        cyc(17);
        bcd = 16'h5678;
        cyc(1);
        lit("tear_d2", 4'b1011, 7'h24, 1'b1);
        cyc(8);
        lit("tear_d3", 4'b0111, 7'h79, 1'b1);
        cyc(6);
        chk("tear_fs", int'(frame_start), 1);
        cyc(2);
        lit("new_d0", 4'b1110, 7'h00, 1'b1);

        // Leading zeros
        bcd      = 16'h0050;
        blank_lz = 1'b1;
        goto(0);
        goto(2);
        lit("lz_d0", 4'b1110, 7'h40, 1'b1);
        goto(10);
        lit("lz_d1", 4'b1101, 7'h12, 1'b1);
        goto(18);
        lit("lz_d2", 4'b1011, 7'h7F, 1'b1);
        goto(26);
        lit("lz_d3", 4'b0111, 7'h7F, 1'b1);
        bcd   = 16'h0000;
        dp_in = 4'b0100;
        goto(0);
        goto(10);
        lit("lzdp_d1", 4'b1101, 7'h40, 1'b1);
        goto(18);
        lit("lzdp_d2", 4'b1011, 7'h40, 1'b0);
        goto(26);
        lit("lzdp_d3", 4'b0111, 7'h7F, 1'b1);
        dp_in = 4'b0000;
        goto(0);
        goto(2);
        lit("zero_d0", 4'b1110, 7'h40, 1'b1);
        goto(10);
        lit("zero_d1", 4'b1101, 7'h7F, 1'b1);

        // Invalid code shows dash and still blocks nothing above
        bcd = 16'h00A9;
        goto(0);
        goto(2);
        lit("inv_d0", 4'b1110, 7'h10, 1'b1);
        goto(10);
        lit("inv_d1", 4'b1101, 7'h3F, 1'b1);
        goto(18);
        lit("inv_d2", 4'b1011, 7'h7F, 1'b1);
        blank_lz = 1'b0;
        goto(0);
        goto(26);
        lit("nolz_d3", 4'b0111, 7'h40, 1'b1);

        // Enable drop at idx 2
        goto(17);
        en = 1'b0;
        cyc(1);
        lit("en0", 4'hF, 7'h7F, 1'b1);
        chk("en0_fs", int'(frame_start), 0);
        cyc(2);
        bcd = 16'h9087;
        en  = 1'b1;
        cyc(1);
        chk("en1_fs", int'(frame_start), 1);
        chk("en1_an", int'(an), 4'hF);
        cyc(1);
        lit("en1_d0", 4'b1110, 7'h78, 1'b1);
        goto(26);
        lit("en1_d3", 4'b0111, 7'h10, 1'b1);

        // Async reset mid-SHOW
        goto(12);
        #2;
        mr = 1'b1;
        #1;
        lit("mr_async", 4'hF, 7'h7F, 1'b1);
        @(negedge clk);
        mr = 1'b0;
        cyc(1);
        chk("mr_fs", int'(frame_start), 1);
        chk("mr_an", int'(an), 4'hF);
        cyc(1);
        lit("mr_d0", 4'b1110, 7'h78, 1'b1);
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
